// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, datapath widths and
// instruction field positions used by fetch_unit and Control.
package cpu_pkg;

   localparam int unsigned PC_W       = 10;
   localparam int unsigned INSTR_W    = 9;
   localparam int unsigned OPCODE_MSB = 8;
   localparam int unsigned OPCODE_LSB = 6;
   localparam int unsigned FUNCT_MSB  = 5;
   localparam int unsigned FUNCT_LSB  = 3;
   localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
   localparam int unsigned FUNCT_W    = FUNCT_MSB - FUNCT_LSB + 1;
   localparam int unsigned COUNT_W    = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      RUN    = 2'd2,
      HALTED = 2'd3
   } fetch_state_e;

   // A branch is taken when unconditional, or conditional with Zero set.
   function automatic logic branch_taken(input logic branch,
                                         input logic branch_cond,
                                         input logic zero);
      return branch & (~branch_cond | zero);
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, drives the synchronous-read
// instruction ROM, inserts the one-cycle fill bubble after start/branch and
// counts retired instructions.
module fetch_unit
   import cpu_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                Start,
   input  logic [INSTR_W-1:0]  Instr,
   input  logic                Branch,
   input  logic                BranchCond,
   input  logic                Zero,
   input  logic [PC_W-1:0]     Target,
   input  logic                Halt,
   output logic [PC_W-1:0]     InstrAddr,
   output logic [OPCODE_W-1:0] Opcode,
   output logic [FUNCT_W-1:0]  Funct,
   output logic                InstrValid,
   output logic                Busy,
   output logic                Done,
   output logic [COUNT_W-1:0]  InstrCount
);

   fetch_state_e        state, state_n;
   logic [PC_W-1:0]     pc, pc_n;
   logic [COUNT_W-1:0]  count, count_n;
   logic                valid_q, busy_q, done_q;
   logic                taken;
   logic                unused_bits;

   assign taken = branch_taken(Branch, BranchCond, Zero);

   // State, PC, retire counter and status flags; flags follow the next state.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= IDLE;
         pc      <= '0;
         count   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         count   <= count_n;
         valid_q <= (state_n == RUN);
         busy_q  <= (state_n == PRIME) || (state_n == RUN);
         done_q  <= (state_n == HALTED);
      end
   end

   // Next-state, next-PC and retire-count logic.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      count_n = count;
      case (state)
         IDLE: begin
            pc_n = '0;
            if (Start) begin
               state_n = PRIME;
               count_n = '0;
            end
         end
         PRIME: begin
            // ROM is reading PC now; advance so RUN streams with no bubbles.
            pc_n    = pc + 1'b1;
            state_n = RUN;
         end
         RUN: begin
            if (count != '1) begin
               count_n = count + 1'b1;
            end
            if (Halt) begin
               state_n = HALTED;
            end else if (taken) begin
               // Word already fetched at PC is dropped by the PRIME bubble.
               pc_n    = Target;
               state_n = PRIME;
            end else begin
               pc_n = pc + 1'b1;
            end
         end
         HALTED: begin
            if (Start) begin
               state_n = PRIME;
               pc_n    = '0;
               count_n = '0;
            end
         end
         default: begin
            state_n = IDLE;
            pc_n    = '0;
         end
      endcase
   end

   // Output mapping; opcode/funct are plain slices of the ROM word.
   assign InstrAddr  = pc;
   assign InstrCount = count;
   assign InstrValid = valid_q;
   assign Busy       = busy_q;
   assign Done       = done_q;
   assign Opcode     = Instr[OPCODE_MSB:OPCODE_LSB];
   assign Funct      = Instr[FUNCT_MSB:FUNCT_LSB];
   assign unused_bits = ^Instr[FUNCT_LSB-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM and Control models, program-level reference
// model feeding a scoreboard, and a monitor checking every valid instruction.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int DEPTH = 1024;
   localparam logic [2:0] OP_BR   = 3'b001;
   localparam logic [2:0] OP_BEZ  = 3'b010;
   localparam logic [2:0] OP_HALT = 3'b111;

   logic                CLK = 1'b0;
   logic                RESET_N;
   logic                Start;
   logic [INSTR_W-1:0]  Instr;
   logic                Branch, BranchCond, Zero, Halt;
   logic [PC_W-1:0]     Target;
   logic [PC_W-1:0]     InstrAddr;
   logic [OPCODE_W-1:0] Opcode;
   logic [FUNCT_W-1:0]  Funct;
   logic                InstrValid, Busy, Done;
   logic [COUNT_W-1:0]  InstrCount;

   fetch_unit dut (
      .CLK(CLK), .RESET_N(RESET_N), .Start(Start), .Instr(Instr),
      .Branch(Branch), .BranchCond(BranchCond), .Zero(Zero),
      .Target(Target), .Halt(Halt), .InstrAddr(InstrAddr),
      .Opcode(Opcode), .Funct(Funct), .InstrValid(InstrValid),
      .Busy(Busy), .Done(Done), .InstrCount(InstrCount)
   );

   always #5 CLK = ~CLK;

   // Program memory plus per-address control attributes.
   logic [INSTR_W-1:0] rom      [DEPTH];
   logic [PC_W-1:0]    tgt      [DEPTH];
   logic               zero_at  [DEPTH];
   logic               force_br [DEPTH];
   logic [PC_W-1:0]    rom_addr;

   // Synchronous-read ROM; remembers which address the word came from.
   always @(posedge CLK) begin
      Instr    <= rom[InstrAddr];
      rom_addr <= InstrAddr;
   end

   // Control model decoding the current ROM word.
   always_comb begin
      Halt       = (Instr[8:6] == OP_HALT);
      BranchCond = (Instr[8:6] == OP_BEZ);
      Branch     = (Instr[8:6] == OP_BR) || (Instr[8:6] == OP_BEZ) ||
                   (Halt && force_br[rom_addr]);
      Zero       = zero_at[rom_addr];
      Target     = tgt[rom_addr];
   end

   typedef struct {
      int addr;
      int op;
      int fn;
      int cnt;
      int gap;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   sb_on    = 1'b0;
   int   gap_cnt  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: every valid instruction is compared with the next expected one.
   always @(negedge CLK) begin
      if (!sb_on || !RESET_N) begin
         gap_cnt = 0;
      end else if (InstrValid) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_valid", int'(InstrValid), 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_addr",   int'(InstrAddr),  e.addr);
            check("sb_opcode", int'(Opcode),     e.op);
            check("sb_funct",  int'(Funct),      e.fn);
            check("sb_count",  int'(InstrCount), e.cnt);
            check("sb_bubble", gap_cnt,          e.gap);
         end
         gap_cnt = 0;
      end else if (Busy) begin
         gap_cnt++;
      end else begin
         gap_cnt = 0;
      end
   end

   // Reference model: walk the program from PC 0 and queue each retirement.
   task automatic build(input int max_steps, output bit halted,
                        output int fin_cnt, output int fin_addr);
      int pc  = 0;
      int cnt = 0;
      int gap = 1;
      logic [INSTR_W-1:0] w;
      logic [2:0] op;
      exp_t e;
      halted   = 1'b0;
      fin_addr = 0;
      exp_q.delete();
      for (int s = 0; s < max_steps; s++) begin
         w      = rom[pc];
         op     = w[8:6];
         e.addr = (pc + 1) % DEPTH;
         e.op   = int'(op);
         e.fn   = int'(w[5:3]);
         e.cnt  = cnt;
         e.gap  = gap;
         exp_q.push_back(e);
         if (cnt < 65535) cnt++;
         if (op == OP_HALT) begin
            halted   = 1'b1;
            fin_addr = (pc + 1) % DEPTH;
            break;
         end
         if (op == OP_BR || (op == OP_BEZ && zero_at[pc])) begin
            pc  = int'(tgt[pc]);
            gap = 1;
         end else begin
            pc  = (pc + 1) % DEPTH;
            gap = 0;
         end
      end
      fin_cnt = cnt;
   endtask

   function automatic logic [2:0] alu_op();
      logic [2:0] ops [5];
      ops[0] = 3'b000; ops[1] = 3'b011; ops[2] = 3'b100;
      ops[3] = 3'b101; ops[4] = 3'b110;
      return ops[$urandom_range(0, 4)];
   endfunction

   task automatic fill_alu();
      for (int i = 0; i < DEPTH; i++) begin
         rom[i]      = {alu_op(), 6'($urandom)};
         tgt[i]      = '0;
         zero_at[i]  = 1'b0;
         force_br[i] = 1'b0;
      end
   endtask

   task automatic gen_random();
      int r;
      for (int i = 0; i < DEPTH; i++) begin
         r = int'($urandom_range(0, 23));
         if (r == 0)     rom[i] = {OP_HALT, 6'($urandom)};
         else if (r < 3) rom[i] = {OP_BR,   6'($urandom)};
         else if (r < 5) rom[i] = {OP_BEZ,  6'($urandom)};
         else            rom[i] = {alu_op(), 6'($urandom)};
         tgt[i]      = PC_W'($urandom);
         zero_at[i]  = 1'($urandom);
         force_br[i] = 1'($urandom);
      end
   endtask

   // Start a program, poke Start while busy, then check the halted state.
   task automatic run_prog(input string tag, input int budget);
      bit halted;
      int fin_cnt, fin_addr;
      build(300, halted, fin_cnt, fin_addr);
      sb_on = 1'b1;
      @(negedge CLK); Start = 1'b1;
      @(negedge CLK); Start = 1'b0;
      check({tag, "_start_addr"},  int'(InstrAddr),  0);
      check({tag, "_start_count"}, int'(InstrCount), 0);
      check({tag, "_start_busy"},  int'(Busy),       1);
      check({tag, "_start_valid"}, int'(InstrValid), 0);
      for (int c = 0; c < budget && !Done; c++) begin
         @(negedge CLK);
         Start = Busy ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      Start = 1'b0;
      check({tag, "_done"},       int'(Done),       1);
      check({tag, "_count"},      int'(InstrCount), fin_cnt);
      check({tag, "_halt_addr"},  int'(InstrAddr),  fin_addr);
      check({tag, "_sb_drained"}, exp_q.size(),     0);
      repeat (3) @(negedge CLK);
      check({tag, "_frozen_addr"},  int'(InstrAddr),  fin_addr);
      check({tag, "_frozen_count"}, int'(InstrCount), fin_cnt);
      check({tag, "_frozen_busy"},  int'(Busy),       0);
      sb_on = 1'b0;
   endtask

   task automatic prog_basic();
      fill_alu();
      rom[0] = 9'b011_000_000;
      rom[1] = 9'b100_001_000;
      rom[2] = 9'b101_010_000;
      rom[3] = 9'b110_011_000;
      rom[4] = {OP_HALT, 6'd0};
   endtask

   initial begin
      bit halted;
      int fin_cnt, fin_addr;

      fill_alu();
      RESET_N = 1'b0;
      Start   = 1'b0;
      repeat (2) @(negedge CLK);
      check("rst_valid", int'(InstrValid), 0);
      check("rst_busy",  int'(Busy),       0);
      check("rst_done",  int'(Done),       0);
      check("rst_addr",  int'(InstrAddr),  0);
      check("rst_count", int'(InstrCount), 0);
      RESET_N = 1'b1;
      repeat (2) @(negedge CLK);
      check("idle_busy", int'(Busy), 0);

      // Straight-line ALU ops then halt.
      prog_basic();
      run_prog("basic", 50);

      // Unconditional branch from 2 to 10; word at 3 must never issue.
      fill_alu();
      rom[2] = {OP_BR, 6'd0}; tgt[2] = 10'd10;
      rom[3] = {OP_HALT, 6'd0};
      rom[10] = {OP_HALT, 6'd5};
      run_prog("br", 50);

      // bez not taken then taken to 20.
      fill_alu();
      rom[1] = {OP_BEZ, 6'd1}; tgt[1] = 10'd20; zero_at[1] = 1'b0;
      rom[2] = {OP_BEZ, 6'd2}; tgt[2] = 10'd20; zero_at[2] = 1'b1;
      rom[3] = {OP_HALT, 6'd0};
      rom[20] = {OP_HALT, 6'd7};
      run_prog("bez", 60);

      // Halt with a simultaneous branch: halt must win.
      fill_alu();
      rom[5] = {OP_HALT, 6'd3}; force_br[5] = 1'b1; tgt[5] = 10'd100;
      run_prog("halt_br", 60);

      // Restart from HALTED.
      prog_basic();
      run_prog("restart", 50);

      // Random programs that are known to halt.
      for (int p = 0; p < 8; p++) begin
         halted = 1'b0;
         for (int t = 0; t < 50 && !halted; t++) begin
            gen_random();
            build(300, halted, fin_cnt, fin_addr);
         end
         run_prog("rand", 800);
      end

      // Long straight run: PC wraps, counter saturates, then reset mid-run.
      fill_alu();
      build(65600, halted, fin_cnt, fin_addr);
      sb_on = 1'b1;
      @(negedge CLK); Start = 1'b1;
      @(negedge CLK); Start = 1'b0;
      for (int c = 0; c < 70000 && exp_q.size() != 0; c++) @(posedge CLK);
      sb_on = 1'b0;
      check("long_sb_drained", exp_q.size(), 0);
      #1;
      check("long_count_sat", int'(InstrCount), 65535);
      check("long_valid",     int'(InstrValid), 1);
      #1 RESET_N = 1'b0;
      #1;
      check("arst_valid", int'(InstrValid), 0);
      check("arst_busy",  int'(Busy),       0);
      check("arst_done",  int'(Done),       0);
      check("arst_addr",  int'(InstrAddr),  0);
      check("arst_count", int'(InstrCount), 0);
      #1 RESET_N = 1'b1;
      repeat (3) @(negedge CLK);
      check("post_rst_busy", int'(Busy),      0);
      check("post_rst_addr", int'(InstrAddr), 0);

      prog_basic();
      run_prog("after_rst", 50);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
